// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles a 16-bit instruction from two byte reads
// (high byte at pc, low byte at pc+1) and hands it to the decoder via valid/ready.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_en,
    input  logic [7:0]  redirect_addr,
    output logic [15:0] inst,
    output logic [7:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [7:0]  hi_q;
    logic [15:0] inst_q;
    logic [7:0]  inst_pc_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HI;
            pc_q      <= RESET_PC & 8'hFE;
            hi_q      <= 8'h00;
            inst_q    <= 16'h0000;
            inst_pc_q <= 8'h00;
            valid_q   <= 1'b0;
        end else if (redirect_en) begin
            // Redirect wins over any ack or consume landing in the same cycle.
            pc_q    <= redirect_addr & 8'hFE;
            valid_q <= 1'b0;
            state_q <= S_HI;
        end else begin
            case (state_q)
                S_HI: begin
                    if (mem_ack) begin
                        hi_q    <= mem_rdata;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (mem_ack) begin
                        inst_q    <= {hi_q, mem_rdata};
                        inst_pc_q <= pc_q;
                        valid_q   <= 1'b1;
                        state_q   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_q + 8'd2;
                        state_q <= S_HI;
                    end
                end
                default: state_q <= S_HI;
            endcase
        end
    end

    // Request is held off while reset is asserted so the reset cycle never issues a read.
    assign mem_req    = !rst && (state_q != S_OUT);
    assign mem_addr   = (state_q == S_LO) ? (pc_q + 8'd1) : pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable wait states,
// scoreboard queue of expected {inst, inst_pc}, second instance for PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_ack;
    logic [7:0]  mem_addr, mem_rdata;
    logic        redirect_en;
    logic [7:0]  redirect_addr;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid, inst_ready;

    logic        mem_req1, mem_ack1;
    logic [7:0]  mem_addr1, mem_rdata1;
    logic [15:0] inst1;
    logic [7:0]  inst_pc1;
    logic        inst_valid1, inst_ready1;

    int          total = 0;
    int          bad = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        ack_force = 1'b0;
    logic [23:0] sb_q[$];
    logic [23:0] sb1_q[$];

    always #5 clk = ~clk;

    // Memory model: byte[a] = a ^ 8'h5A, ack after wait_cfg stalled request cycles.
    assign mem_ack   = ack_force | (mem_req && (wait_cnt >= wait_cfg));
    assign mem_rdata = ack_force ? 8'hEE : (mem_addr ^ 8'h5A);
    assign mem_ack1   = mem_req1;
    assign mem_rdata1 = mem_addr1 ^ 8'h5A;

    always @(posedge clk) begin
        if (mem_req && !mem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack1), .mem_rdata(mem_rdata1),
        .redirect_en(1'b0), .redirect_addr(8'h00),
        .inst(inst1), .inst_pc(inst_pc1), .inst_valid(inst_valid1), .inst_ready(inst_ready1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input logic [7:0] pc);
        logic [7:0] lo_addr;
        lo_addr = pc + 8'd1;
        return {pc ^ 8'h5A, lo_addr ^ 8'h5A, pc};
    endfunction

    task automatic pop_check(input string tag);
        logic [23:0] e;
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_inst"}, 32'(inst), 32'(e[23:8]));
            check({tag, "_pc"}, 32'(inst_pc), 32'(e[7:0]));
        end
    endtask

    task automatic pop_check1(input string tag);
        logic [23:0] e;
        check({tag, "_valid"}, 32'(inst_valid1), 32'd1);
        if (sb1_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb1_q.pop_front();
            check({tag, "_inst"}, 32'(inst1), 32'(e[23:8]));
            check({tag, "_pc"}, 32'(inst_pc1), 32'(e[7:0]));
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_ready = 1'b0;
        inst_ready1 = 1'b0;
        redirect_en = 1'b0;
        redirect_addr = 8'h00;
        step();
        step();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", 32'(inst), 32'h0);
        check("rst_inst_pc", 32'(inst_pc), 32'h0);
        rst = 1'b0;
        #1;

        // Zero-wait fetch from 00, plus wrap instance from FE.
        sb_q.push_back(exp_word(8'h00));
        sb1_q.push_back(exp_word(8'hFE));
        check("s1_req_hi", 32'(mem_req), 32'd1);
        check("s1_addr_hi", 32'(mem_addr), 32'h00);
        check("wrap_addr_hi", 32'(mem_addr1), 32'hFE);
        step();
        check("s1_addr_lo", 32'(mem_addr), 32'h01);
        check("wrap_addr_lo", 32'(mem_addr1), 32'hFF);
        check("s1_valid_early", 32'(inst_valid), 32'd0);
        step();
        pop_check("s1_first");
        pop_check1("wrap_first");
        check("s1_req_out", 32'(mem_req), 32'd0);
        inst_ready = 1'b1;
        inst_ready1 = 1'b1;
        step();
        inst_ready = 1'b0;
        inst_ready1 = 1'b0;
        check("s1_valid_drop", 32'(inst_valid), 32'd0);
        check("s1_addr_next_hi", 32'(mem_addr), 32'h02);
        check("wrap_addr_next", 32'(mem_addr1), 32'h00);
        sb_q.push_back(exp_word(8'h02));
        step();
        check("s1_addr_next_lo", 32'(mem_addr), 32'h03);
        step();
        pop_check("s1_second");

        // Backpressure with a stray ack while no request is pending.
        ack_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("backpressure cycle %0d inst=%h pc=%h req=%b", i, inst, inst_pc, mem_req);
            check("s3_inst_hold", 32'(inst), 32'h5859);
            check("s3_pc_hold", 32'(inst_pc), 32'h02);
            check("s3_req_low", 32'(mem_req), 32'd0);
            check("s3_valid_hold", 32'(inst_valid), 32'd1);
        end
        ack_force = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("s3_addr_after", 32'(mem_addr), 32'h04);

        // Three wait states per byte.
        wait_cfg = 3;
        #1;
        sb_q.push_back(exp_word(8'h04));
        for (int i = 0; i < 8; i++) begin
            check("s2_req_held", 32'(mem_req), 32'd1);
            check("s2_addr_held", 32'(mem_addr), (i < 4) ? 32'h04 : 32'h05);
            check("s2_valid_low", 32'(inst_valid), 32'd0);
            step();
        end
        pop_check("s2_wait");
        wait_cfg = 0;

        // Redirect from S_OUT to 10, fetch it.
        redirect_en = 1'b1;
        redirect_addr = 8'h10;
        step();
        redirect_en = 1'b0;
        check("s5_pre_addr", 32'(mem_addr), 32'h10);
        check("s5_pre_valid", 32'(inst_valid), 32'd0);
        sb_q.push_back(exp_word(8'h10));
        step();
        step();
        pop_check("s5_at10");

        // Redirect and consume together: pc goes to target, not 12.
        redirect_en = 1'b1;
        redirect_addr = 8'h31;
        inst_ready = 1'b1;
        step();
        redirect_en = 1'b0;
        inst_ready = 1'b0;
        check("s5_redir_addr", 32'(mem_addr), 32'h30);
        check("s5_redir_valid", 32'(inst_valid), 32'd0);
        sb_q.push_back(exp_word(8'h30));
        step();
        step();
        pop_check("s5_target");

        // Redirect to 41 during S_LO while ack arrives.
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("s4_addr_hi", 32'(mem_addr), 32'h32);
        step();
        check("s4_addr_lo", 32'(mem_addr), 32'h33);
        check("s4_ack_same", 32'(mem_ack), 32'd1);
        redirect_en = 1'b1;
        redirect_addr = 8'h41;
        step();
        redirect_en = 1'b0;
        check("s4_req_new", 32'(mem_req), 32'd1);
        check("s4_addr_new", 32'(mem_addr), 32'h40);
        check("s4_valid_drop", 32'(inst_valid), 32'd0);
        sb_q.push_back(exp_word(8'h40));
        step();
        step();
        pop_check("s4_redirect");

        // Reset mid-fetch drops the partial byte.
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        step();
        check("rst2_in_lo", 32'(mem_addr), 32'h43);
        rst = 1'b1;
        step();
        check("rst2_req", 32'(mem_req), 32'd0);
        check("rst2_valid", 32'(inst_valid), 32'd0);
        check("rst2_inst", 32'(inst), 32'h0);
        rst = 1'b0;
        #1;
        check("rst2_addr", 32'(mem_addr), 32'h00);
        sb_q.push_back(exp_word(8'h00));
        step();
        step();
        pop_check("rst2_refetch");
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
